// File: rtl/inst_fetch.sv
// Instruction fetch unit: bus master for the instruction port, PC sequencing,
// and an 8-entry circular return stack for jsb/ret.
module inst_fetch (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        inst_cyc_o,
    output logic        inst_stb_o,
    output logic [11:0] inst_adr_o,
    input  logic        inst_ack_i,
    input  logic [17:0] inst_dat_i,
    output logic [17:0] ir_o,
    output logic        ir_valid_o,
    input  logic        next_i,
    input  logic [2:0]  pc_sel_i,
    input  logic [11:0] target_i,
    input  logic [7:0]  disp_i,
    output logic [11:0] pc_o,
    output logic        stk_ovf_o,
    output logic        stk_unf_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [2:0] SEL_SEQ    = 3'd0;
    localparam logic [2:0] SEL_JUMP   = 3'd1;
    localparam logic [2:0] SEL_BRANCH = 3'd2;
    localparam logic [2:0] SEL_JSB    = 3'd3;
    localparam logic [2:0] SEL_RET    = 3'd4;

    state_t      state_r;
    logic [11:0] pc_r;
    logic [17:0] ir_r;
    logic        ir_valid_r;
    logic [2:0]  stk_ptr_r;
    logic [3:0]  stk_depth_r;
    logic        stk_ovf_r;
    logic        stk_unf_r;
    logic [11:0] stack_r [8];

    logic [11:0] pc_inc_s;
    logic [11:0] disp_ext_s;
    logic [2:0]  pop_ptr_s;
    logic [11:0] next_pc_s;
    logic        do_push_s;
    logic        do_pop_s;
    logic        advance_s;

    // Next-PC selection and return-stack push/pop decode
    always_comb begin
        pc_inc_s   = pc_r + 12'd1;
        disp_ext_s = {{4{disp_i[7]}}, disp_i};
        pop_ptr_s  = stk_ptr_r - 3'd1;
        advance_s  = (state_r == HOLD) && next_i;
        next_pc_s  = pc_inc_s;
        do_push_s  = 1'b0;
        do_pop_s   = 1'b0;
        case (pc_sel_i)
            SEL_SEQ:    next_pc_s = pc_inc_s;
            SEL_JUMP:   next_pc_s = target_i;
            SEL_BRANCH: next_pc_s = pc_inc_s + disp_ext_s;
            SEL_JSB: begin
                next_pc_s = target_i;
                do_push_s = 1'b1;
            end
            SEL_RET: begin
                // An empty stack still reads the slot below the pointer.
                next_pc_s = stack_r[pop_ptr_s];
                do_pop_s  = 1'b1;
            end
            default:    next_pc_s = pc_inc_s;
        endcase
    end

    // Control FSM, PC, instruction register and stack bookkeeping
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= IDLE;
            pc_r        <= 12'd0;
            ir_r        <= 18'd0;
            ir_valid_r  <= 1'b0;
            stk_ptr_r   <= 3'd0;
            stk_depth_r <= 4'd0;
            stk_ovf_r   <= 1'b0;
            stk_unf_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: state_r <= FETCH;
                FETCH: begin
                    if (inst_ack_i) begin
                        ir_r       <= inst_dat_i;
                        ir_valid_r <= 1'b1;
                        state_r    <= HOLD;
                    end
                end
                HOLD: begin
                    if (next_i) begin
                        pc_r       <= next_pc_s;
                        ir_valid_r <= 1'b0;
                        state_r    <= FETCH;
                        if (do_push_s) begin
                            stk_ptr_r <= stk_ptr_r + 3'd1;
                            if (stk_depth_r == 4'd8) begin
                                stk_ovf_r <= 1'b1;
                            end else begin
                                stk_depth_r <= stk_depth_r + 4'd1;
                            end
                        end
                        if (do_pop_s) begin
                            stk_ptr_r <= pop_ptr_s;
                            if (stk_depth_r == 4'd0) begin
                                stk_unf_r <= 1'b1;
                            end else begin
                                stk_depth_r <= stk_depth_r - 4'd1;
                            end
                        end
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // Return-stack storage; a full stack overwrites its oldest slot
    always_ff @(posedge clk_i) begin
        if (!rst_i && advance_s && do_push_s) begin
            stack_r[stk_ptr_r] <= pc_inc_s;
        end
    end

    assign inst_cyc_o = (state_r == FETCH);
    assign inst_stb_o = (state_r == FETCH);
    assign inst_adr_o = pc_r;
    assign pc_o       = pc_r;
    assign ir_o       = ir_r;
    assign ir_valid_o = ir_valid_r;
    assign stk_ovf_o  = stk_ovf_r;
    assign stk_unf_o  = stk_unf_r;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed testbench for inst_fetch with hand-computed expectations.
module tb_inst_fetch;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        inst_cyc_o;
    logic        inst_stb_o;
    logic [11:0] inst_adr_o;
    logic        inst_ack_i;
    logic [17:0] inst_dat_i;
    logic [17:0] ir_o;
    logic        ir_valid_o;
    logic        next_i;
    logic [2:0]  pc_sel_i;
    logic [11:0] target_i;
    logic [7:0]  disp_i;
    logic [11:0] pc_o;
    logic        stk_ovf_o;
    logic        stk_unf_o;

    int checks = 0;
    int errors = 0;

    inst_fetch dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .inst_cyc_o (inst_cyc_o),
        .inst_stb_o (inst_stb_o),
        .inst_adr_o (inst_adr_o),
        .inst_ack_i (inst_ack_i),
        .inst_dat_i (inst_dat_i),
        .ir_o       (ir_o),
        .ir_valid_o (ir_valid_o),
        .next_i     (next_i),
        .pc_sel_i   (pc_sel_i),
        .target_i   (target_i),
        .disp_i     (disp_i),
        .pc_o       (pc_o),
        .stk_ovf_o  (stk_ovf_o),
        .stk_unf_o  (stk_unf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle on the falling edge for sampling/driving.
    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // From FETCH: ack one word, then retire it with the given PC source.
    task automatic fetch_exec(input logic [17:0] dat, input logic [2:0] sel,
                              input logic [11:0] tgt, input logic [7:0] disp);
        inst_ack_i = 1'b1;
        inst_dat_i = dat;
        step();
        inst_ack_i = 1'b0;
        next_i     = 1'b1;
        pc_sel_i   = sel;
        target_i   = tgt;
        disp_i     = disp;
        step();
        next_i     = 1'b0;
    endtask

    initial begin
        logic [11:0] adr_hold;
        rst_i      = 1'b1;
        inst_ack_i = 1'b0;
        inst_dat_i = 18'd0;
        next_i     = 1'b0;
        pc_sel_i   = 3'd0;
        target_i   = 12'd0;
        disp_i     = 8'd0;
        step();
        step();
        chk("rst_cyc", {31'd0, inst_cyc_o}, 32'd0);
        chk("rst_pc", {20'd0, pc_o}, 32'd0);
        chk("rst_ir", {14'd0, ir_o}, 32'd0);
        chk("rst_valid", {31'd0, ir_valid_o}, 32'd0);
        chk("rst_flags", {30'd0, stk_ovf_o, stk_unf_o}, 32'd0);

        // Release: IDLE edge, then FETCH at address 0
        rst_i = 1'b0;
        step();
        chk("rel_cyc", {30'd0, inst_cyc_o, inst_stb_o}, 32'd3);
        chk("rel_adr", {20'd0, inst_adr_o}, 32'd0);

        inst_ack_i = 1'b1;
        inst_dat_i = 18'h2A5A5;
        step();
        inst_ack_i = 1'b0;
        chk("ack_ir", {14'd0, ir_o}, 32'h2A5A5);
        chk("ack_valid", {31'd0, ir_valid_o}, 32'd1);
        chk("ack_cyc", {31'd0, inst_cyc_o}, 32'd0);
        next_i   = 1'b1;
        pc_sel_i = 3'd0;
        step();
        next_i = 1'b0;
        chk("seq_adr", {20'd0, inst_adr_o}, 32'h001);
        chk("seq_cyc", {31'd0, inst_cyc_o}, 32'd1);
        chk("seq_valid", {31'd0, ir_valid_o}, 32'd0);
        chk("seq_ir_kept", {14'd0, ir_o}, 32'h2A5A5);

        // PC arithmetic: jump, negative branch, wrap on seq, seq alias
        fetch_exec(18'h00001, 3'd1, 12'h010, 8'h00);
        chk("jump_pc", {20'd0, pc_o}, 32'h010);
        fetch_exec(18'h00002, 3'd2, 12'hABC, 8'hF0);
        chk("branch_pc", {20'd0, pc_o}, 32'h001);
        fetch_exec(18'h00003, 3'd2, 12'h000, 8'h05);
        chk("branch_fwd_pc", {20'd0, pc_o}, 32'h007);
        fetch_exec(18'h00004, 3'd1, 12'hFFF, 8'h00);
        chk("jump_fff", {20'd0, pc_o}, 32'hFFF);
        fetch_exec(18'h00005, 3'd0, 12'h123, 8'h7F);
        chk("wrap_pc", {20'd0, pc_o}, 32'h000);
        fetch_exec(18'h00006, 3'd6, 12'h123, 8'h7F);
        chk("sel6_seq", {20'd0, pc_o}, 32'h001);

        // Stall in FETCH for five cycles; next_i alone is ignored
        next_i   = 1'b1;
        pc_sel_i = 3'd1;
        target_i = 12'h555;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_cyc", {30'd0, inst_cyc_o, inst_stb_o}, 32'd3);
            chk("stall_adr", {20'd0, inst_adr_o}, 32'h001);
        end
        next_i = 1'b0;
        chk("stall_valid", {31'd0, ir_valid_o}, 32'd0);

        // Spurious ack while in HOLD must not disturb ir_o or the state
        inst_ack_i = 1'b1;
        inst_dat_i = 18'h13579;
        step();
        inst_dat_i = 18'h3FFFF;
        step();
        step();
        inst_ack_i = 1'b0;
        chk("hold_ir", {14'd0, ir_o}, 32'h13579);
        chk("hold_cyc", {31'd0, inst_cyc_o}, 32'd0);
        chk("hold_valid", {31'd0, ir_valid_o}, 32'd1);
        chk("hold_pc", {20'd0, pc_o}, 32'h001);
        next_i   = 1'b1;
        pc_sel_i = 3'd0;
        step();
        next_i = 1'b0;
        chk("hold_exit_adr", {20'd0, inst_adr_o}, 32'h002);

        // Reset again; ack and next_i during IDLE are ignored
        rst_i = 1'b1;
        step();
        rst_i      = 1'b0;
        inst_ack_i = 1'b1;
        inst_dat_i = 18'h0BEEF;
        next_i     = 1'b1;
        step();
        inst_ack_i = 1'b0;
        next_i     = 1'b0;
        chk("idle_ir", {14'd0, ir_o}, 32'd0);
        chk("idle_valid", {31'd0, ir_valid_o}, 32'd0);
        chk("idle_cyc", {31'd0, inst_cyc_o}, 32'd1);
        chk("idle_pc", {20'd0, pc_o}, 32'd0);

        // Nine nested calls overflow the 8-deep stack
        for (int n = 1; n <= 9; n++) begin
            fetch_exec(18'h10000, 3'd3, 12'h100 + 12'(n), 8'h00);
            chk("jsb_pc", {20'd0, pc_o}, 32'h100 + 32'(n));
            if (n == 8) chk("ovf_before", {31'd0, stk_ovf_o}, 32'd0);
        end
        chk("ovf_after", {31'd0, stk_ovf_o}, 32'd1);
        for (int k = 0; k < 8; k++) begin
            fetch_exec(18'h20000, 3'd4, 12'h000, 8'h00);
            chk("ret_pc", {20'd0, pc_o}, 32'h109 - 32'(k));
            chk("ret_unf", {31'd0, stk_unf_o}, 32'd0);
        end
        fetch_exec(18'h20000, 3'd4, 12'h000, 8'h00);
        chk("unf_after", {31'd0, stk_unf_o}, 32'd1);
        chk("ovf_sticky", {31'd0, stk_ovf_o}, 32'd1);

        // Reset coincident with ack in FETCH wins
        adr_hold = inst_adr_o;
        chk("pre_rst_cyc", {31'd0, inst_cyc_o}, 32'd1);
        rst_i      = 1'b1;
        inst_ack_i = 1'b1;
        inst_dat_i = 18'h2FFFF;
        step();
        rst_i      = 1'b0;
        inst_ack_i = 1'b0;
        chk("rst_ack_valid", {31'd0, ir_valid_o}, 32'd0);
        chk("rst_ack_ir", {14'd0, ir_o}, 32'd0);
        chk("rst_ack_pc", {20'd0, pc_o}, 32'd0);
        chk("rst_ack_cyc", {31'd0, inst_cyc_o}, 32'd0);
        chk("rst_ack_flags", {30'd0, stk_ovf_o, stk_unf_o}, 32'd0);
        step();
        chk("rst_ack_refetch", {19'd0, inst_cyc_o, inst_adr_o}, {19'd0, 1'b1, 12'h000});
        chk("rst_ack_adr_changed", {31'd0, (adr_hold != inst_adr_o)}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
